// File: rtl/pipe_column_buffer.sv
// Column store for the scrolling pipe field: shifts in one column word per scroll
// step, serves registered pixel reads, detects bird collisions and keeps the score.
module pipe_column_buffer #(
  parameter int COLS     = 20,
  parameter int ROWS     = 30,
  parameter int BIRD_COL = 4,
  parameter int X_W      = 5,
  parameter int Y_W      = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            shift_en,
  input  logic [ROWS-1:0] col_in,
  input  logic [X_W-1:0]  rd_x,
  input  logic [Y_W-1:0]  rd_y,
  output logic            rd_pixel,
  input  logic [Y_W-1:0]  bird_y,
  output logic            hit,
  output logic            running,
  output logic [7:0]      score
);

  typedef enum logic {RUN = 1'b0, HIT = 1'b1} state_t;

  state_t                     state_reg;
  logic [COLS-1:0][ROWS-1:0]  col_reg;
  logic [COLS-1:0][ROWS-1:0]  col_shifted;
  logic                       rd_pixel_reg;
  logic                       hit_reg;
  logic                       running_reg;
  logic [7:0]                 score_reg;

  logic [ROWS-1:0]            bird_col_bits;
  logic [ROWS-1:0]            bird_shifted;
  logic [ROWS-1:0]            pixel_row;
  logic [ROWS-1:0]            pixel_shifted;
  logic                       coll;
  logic                       pass;
  logic                       pixel_next;

  // Left-shifted view of the store with the incoming word in the entry column.
  genvar gi;
  generate
    for (gi = 0; gi < COLS-1; gi++) begin : g_shift
      assign col_shifted[gi] = col_reg[gi+1];
    end
  endgenerate
  assign col_shifted[COLS-1] = col_in;

  // Right-shifting a row word by an out-of-range index yields 0, which gives
  // the "row beyond the column never matches" behaviour for free.
  always_comb begin
    bird_col_bits = col_reg[BIRD_COL];
    bird_shifted  = bird_col_bits >> bird_y;
    coll          = bird_shifted[0];
    pass          = (|col_reg[BIRD_COL]) && !(|col_reg[BIRD_COL+1]) && !coll;
    pixel_row     = (int'(rd_x) < COLS) ? col_reg[rd_x] : '0;
    pixel_shifted = pixel_row >> rd_y;
    pixel_next    = pixel_shifted[0];
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      col_reg      <= '0;
      rd_pixel_reg <= 1'b0;
      hit_reg      <= 1'b0;
      running_reg  <= 1'b1;
      score_reg    <= 8'd0;
      state_reg    <= RUN;
    end else begin
      rd_pixel_reg <= pixel_next;
      case (state_reg)
        RUN: begin
          // The shift coinciding with a collision is still taken; HIT freezes afterwards.
          if (shift_en) begin
            col_reg <= col_shifted;
            if (pass && score_reg != 8'hFF)
              score_reg <= score_reg + 8'd1;
          end
          if (coll) begin
            state_reg   <= HIT;
            hit_reg     <= 1'b1;
            running_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= HIT;
          hit_reg     <= 1'b1;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rd_pixel = rd_pixel_reg;
  assign hit      = hit_reg;
  assign running  = running_reg;
  assign score    = score_reg;

endmodule

// File: tb/tb_pipe_column_buffer.sv
// Directed bench for pipe_column_buffer: pixel reads go through an expectation
// queue; status outputs are compared directly against bench-derived values.
module tb_pipe_column_buffer;

  localparam logic [29:0] W_A  = 30'h3FFF801F;
  localparam logic [29:0] PIPE = 30'b111110000000000111111111111111;
  localparam logic [29:0] ONES = '1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        shift_en;
  logic [29:0] col_in;
  logic [4:0]  rd_x, rd_y, bird_y;
  logic        rd_pixel, hit, running;
  logic [7:0]  score;

  int    pass_cnt  = 0;
  int    total_cnt = 0;
  bit    exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  pipe_column_buffer #(
    .COLS(20), .ROWS(30), .BIRD_COL(4), .X_W(5), .Y_W(5)
  ) dut (
    .clk(clk), .resetn(resetn), .shift_en(shift_en), .col_in(col_in),
    .rd_x(rd_x), .rd_y(rd_y), .rd_pixel(rd_pixel), .bird_y(bird_y),
    .hit(hit), .running(running), .score(score)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [7:0] obs, logic [7:0] req);
    total_cnt++;
    assert (obs === req) pass_cnt++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic shift(logic [29:0] w);
    shift_en = 1'b1;
    col_in   = w;
    step();
    shift_en = 1'b0;
    col_in   = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    step();
    resetn = 1'b0;
  endtask

  task automatic rd(string tag, int x, int y, bit e);
    bit    req;
    string t;
    rd_x = x[4:0];
    rd_y = y[4:0];
    exp_q.push_back(e);
    tag_q.push_back($sformatf("%s(%0d,%0d)", tag, x, y));
    step();
    req = exp_q.pop_front();
    t   = tag_q.pop_front();
    check(t, {7'd0, rd_pixel}, {7'd0, req});
  endtask

  initial begin
    resetn = 1'b1; shift_en = 1'b0; col_in = '0;
    rd_x = '0; rd_y = '0; bird_y = 5'd15;
    idle(2);
    resetn = 1'b0;
    check("rst_pixel", {7'd0, rd_pixel}, 8'd0);
    check("rst_hit", {7'd0, hit}, 8'd0);
    check("rst_running", {7'd0, running}, 8'd1);
    check("rst_score", score, 8'd0);

    // Idle and sweep an empty field
    idle(10);
    check("idle_hit", {7'd0, hit}, 8'd0);
    check("idle_running", {7'd0, running}, 8'd1);
    check("idle_score", score, 8'd0);
    for (int x = 0; x < 24; x++)
      for (int y = 0; y < 32; y++)
        rd("sweep", x, y, 1'b0);

    // Word walks all the way to col[0]; bird row beyond the field never collides
    bird_y = 5'd30;
    shift(W_A);
    for (int i = 0; i < 19; i++) shift('0);
    check("walk_hit", {7'd0, hit}, 8'd0);
    check("walk_score", score, 8'd1);
    rd("walk", 0, 0, 1'b1);
    rd("walk", 0, 10, 1'b0);
    rd("walk", 0, 29, 1'b1);
    rd("walk", 25, 0, 1'b0);
    rd("walk", 1, 0, 1'b0);

    // Two-wide pipe passes the bird through its gap: scores exactly once
    do_reset();
    bird_y = 5'd20;
    shift(PIPE);
    shift(PIPE);
    for (int i = 0; i < 15; i++) shift('0);
    check("gap_score17", score, 8'd0);
    shift('0);
    check("gap_score18", score, 8'd1);
    shift('0);
    shift('0);
    check("gap_score20", score, 8'd1);
    check("gap_hit", {7'd0, hit}, 8'd0);

    // Pipe reaches the bird column with bird on a pipe row
    do_reset();
    bird_y = 5'd2;
    for (int i = 1; i <= 16; i++) begin
      shift(i <= 2 ? PIPE : 30'd0);
      if (i < 16) idle(1);
    end
    check("coll_hit_pre", {7'd0, hit}, 8'd0);
    idle(1);
    check("coll_hit", {7'd0, hit}, 8'd1);
    check("coll_running", {7'd0, running}, 8'd0);
    for (int i = 0; i < 3; i++) shift(ONES);
    rd("frozen", 4, 2, 1'b1);
    rd("frozen", 5, 2, 1'b1);
    rd("frozen", 3, 2, 1'b0);
    rd("frozen", 6, 2, 1'b0);
    rd("frozen", 4, 20, 1'b0);
    rd("frozen", 19, 0, 1'b0);
    check("frozen_score", score, 8'd0);

    // Collision in the same cycle as a shift: that shift lands, later ones do not
    do_reset();
    bird_y = 5'd2;
    for (int i = 1; i <= 16; i++) shift(i <= 2 ? PIPE : 30'd0);
    check("cs_hit_pre", {7'd0, hit}, 8'd0);
    shift('0);
    check("cs_hit", {7'd0, hit}, 8'd1);
    for (int i = 0; i < 3; i++) shift(ONES);
    rd("cs", 3, 2, 1'b1);
    rd("cs", 4, 2, 1'b1);
    rd("cs", 5, 2, 1'b0);
    rd("cs", 2, 2, 1'b0);
    rd("cs", 19, 0, 1'b0);
    rd("cs", 19, 29, 1'b0);
    check("cs_score", score, 8'd0);

    // Reset wins over a simultaneous shift
    resetn = 1'b1; shift_en = 1'b1; col_in = ONES;
    step();
    resetn = 1'b0; shift_en = 1'b0; col_in = '0;
    check("rs_hit", {7'd0, hit}, 8'd0);
    check("rs_score", score, 8'd0);
    check("rs_running", {7'd0, running}, 8'd1);
    rd("rs", 19, 0, 1'b0);
    rd("rs", 3, 2, 1'b0);
    rd("rs", 4, 2, 1'b0);

    // Alternating single-column pipes: one point per pipe, saturating at 255
    bird_y = 5'd31;
    for (int n = 1; n <= 532; n++) begin
      shift((n % 2 == 1) ? 30'd1 : 30'd0);
      if (n == 17)  check("sat_17", score, 8'd1);
      if (n == 523) check("sat_523", score, 8'd254);
      if (n == 525) check("sat_525", score, 8'd255);
    end
    check("sat_532", score, 8'd255);
    check("sat_hit", {7'd0, hit}, 8'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
